// File: rtl/sim_exit_slave.sv
// Simulation exit / watchdog slave: EXIT, HEARTBEAT and CYCLES registers.
// Define SIM_EXIT_FINISH_EN to print the exit status and end the run itself.
module sim_exit_slave #(
    parameter logic [31:0] baseAddr     = 32'h70000000,
    parameter logic [31:0] WDOG_CYCLES  = 32'd1000000,
    parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] bus_addrData_i,
    input  logic [3:0]  bus_byteEnables_i,
    input  logic [7:0]  bus_burstSize_i,
    input  logic        bus_readNWrite_i,
    input  logic        bus_beginTransaction_i,
    input  logic        bus_endTransaction_i,
    input  logic        bus_dataValid_i,
    output logic [31:0] bus_addrData_o,
    output logic        bus_endTransaction_o,
    output logic        bus_dataValid_o,
    output logic        bus_busy_o,
    output logic        bus_error_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] exit_code_o,
    output logic [31:0] heartbeat_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDEND,
        ERROR
    } state_e;

    localparam logic WDOG_EN = (WDOG_CYCLES != 32'd0);

    state_e      state_q, state_d;
    logic [2:0]  off_q, off_d;
    logic [7:0]  beats_q, beats_d;
    logic        rnw_q, rnw_d;
    logic        drain_q, drain_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_vld_q, rd_vld_d;
    logic        rd_end_q, rd_end_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] wdog_q, wdog_d;
    logic [31:0] hb_q, hb_d;
    logic [31:0] code_q, code_d;
    logic        done_q, done_d;
    logic        tout_q, tout_d;

    logic        hit;
    logic [8:0]  span;
    logic        wr_beat;
    logic        exit_wr;
    logic        hb_wr;
    logic        expire;
    logic        unused_ok;

    assign unused_ok = ^{bus_byteEnables_i, bus_addrData_i[1:0]};

    assign hit  = bus_beginTransaction_i
               && (bus_addrData_i[31:4] == baseAddr[31:4]);
    assign span = {7'd0, bus_addrData_i[3:2]} + {1'b0, bus_burstSize_i};

    assign wr_beat = (state_q == WRITE) && bus_dataValid_i;
    assign exit_wr = wr_beat && (off_q == 3'd0);
    assign hb_wr   = wr_beat && (off_q == 3'd1);
    // Expiry is the decrement that would land on zero this edge.
    assign expire  = WDOG_EN && !done_q && !hb_wr && (wdog_q == 32'd1);

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        beats_d   = beats_q;
        rnw_d     = rnw_q;
        drain_d   = drain_q;
        rd_data_d = 32'd0;
        rd_vld_d  = 1'b0;
        rd_end_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain_q) begin
                    if (bus_endTransaction_i) begin
                        drain_d = 1'b0;
                    end
                end else if (hit) begin
                    off_d   = {1'b0, bus_addrData_i[3:2]};
                    beats_d = bus_burstSize_i;
                    rnw_d   = bus_readNWrite_i;
                    if (span > 9'd3) begin
                        state_d = ERROR;
                    end else if (bus_readNWrite_i) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wr_beat && (off_q < 3'd4)) begin
                    off_d = off_q + 3'd1;
                end
                if (bus_endTransaction_i) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                rd_vld_d = 1'b1;
                // Registered beat: report the counter of the cycle it is seen.
                if (off_q == 3'd2) begin
                    rd_data_d = cyc_q + 32'd1;
                end
                off_d = off_q + 3'd1;
                if (beats_q == 8'd0) begin
                    state_d = RDEND;
                end else begin
                    beats_d = beats_q - 8'd1;
                end
            end
            RDEND: begin
                rd_end_d = 1'b1;
                state_d  = IDLE;
            end
            ERROR: begin
                state_d = IDLE;
                if (!rnw_q && !bus_endTransaction_i) begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d  = cyc_q + 32'd1;
        hb_d   = hb_q;
        wdog_d = wdog_q;
        code_d = code_q;
        done_d = done_q;
        tout_d = tout_q;
        if (hb_wr) begin
            hb_d   = hb_q + 32'd1;
            wdog_d = WDOG_CYCLES;
        end else if (WDOG_EN && !done_q && (wdog_q != 32'd0)) begin
            wdog_d = wdog_q - 32'd1;
        end
        if (exit_wr && !done_q) begin
            done_d = 1'b1;
            code_d = bus_addrData_i;
        end else if (expire) begin
            done_d = 1'b1;
            tout_d = 1'b1;
            code_d = TIMEOUT_CODE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            off_q     <= 3'd0;
            beats_q   <= 8'd0;
            rnw_q     <= 1'b0;
            drain_q   <= 1'b0;
            rd_data_q <= 32'd0;
            rd_vld_q  <= 1'b0;
            rd_end_q  <= 1'b0;
            cyc_q     <= 32'd0;
            wdog_q    <= WDOG_CYCLES;
            hb_q      <= 32'd0;
            code_q    <= 32'd0;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            beats_q   <= beats_d;
            rnw_q     <= rnw_d;
            drain_q   <= drain_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            rd_end_q  <= rd_end_d;
            cyc_q     <= cyc_d;
            wdog_q    <= wdog_d;
            hb_q      <= hb_d;
            code_q    <= code_d;
            done_q    <= done_d;
            tout_q    <= tout_d;
        end
    end

    assign bus_addrData_o       = rd_data_q;
    assign bus_dataValid_o      = rd_vld_q;
    assign bus_endTransaction_o = rd_end_q;
    assign bus_error_o          = (state_q == ERROR);
    assign bus_busy_o           = 1'b0;
    assign done_o               = done_q;
    assign timeout_o            = tout_q;
    assign exit_code_o          = code_q;
    assign heartbeat_cnt_o      = hb_q;

`ifdef SIM_EXIT_FINISH_EN
    logic       done_dly_q;
    logic       fin_run_q;
    logic [4:0] fin_q;

    // Delay the finish so print/UART output can drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_dly_q <= 1'b0;
            fin_run_q  <= 1'b0;
            fin_q      <= 5'd0;
        end else begin
            done_dly_q <= done_q;
            if (done_q && !done_dly_q) begin
                $display("[%0t] EXIT code=0x%08x timeout=%0d heartbeats=%0d",
                         $time, code_q, tout_q, hb_q);
                fin_run_q <= 1'b1;
            end
            if (fin_run_q) begin
                fin_q <= fin_q + 5'd1;
                if (fin_q == 5'd15) begin
                    $finish;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_exit_slave.sv
// Bench for sim_exit_slave: directed bus traffic against a cycle-keyed model.
module tb_sim_exit_slave;

    localparam logic [31:0] BASE = 32'h7000_0000;
    localparam logic [31:0] TOC  = 32'hDEAD_0000;
    localparam int          WD   = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_i;
    logic [3:0]  be_i;
    logic [7:0]  bs_i;
    logic        rnw_i, beg_i, end_i, dv_i;
    logic [31:0] d_o;
    logic        end_o, dv_o, busy_o, err_o;
    logic        done_o, tout_o;
    logic [31:0] code_o, hb_o;

    always #5 clk = ~clk;

    sim_exit_slave #(
        .baseAddr(BASE),
        .WDOG_CYCLES(32'd100),
        .TIMEOUT_CODE(TOC)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus_addrData_i(a_i),
        .bus_byteEnables_i(be_i),
        .bus_burstSize_i(bs_i),
        .bus_readNWrite_i(rnw_i),
        .bus_beginTransaction_i(beg_i),
        .bus_endTransaction_i(end_i),
        .bus_dataValid_i(dv_i),
        .bus_addrData_o(d_o),
        .bus_endTransaction_o(end_o),
        .bus_dataValid_o(dv_o),
        .bus_busy_o(busy_o),
        .bus_error_o(err_o),
        .done_o(done_o),
        .timeout_o(tout_o),
        .exit_code_o(code_o),
        .heartbeat_cnt_o(hb_o)
    );

    int tcyc = 0;
    int errs = 0;
    int checks = 0;

    // Expected effects keyed by the cycle in which they become visible.
    bit          ev_hb[int];
    logic [31:0] ev_exit[int];
    logic [31:0] exp_rd[int];
    bit          exp_end[int];
    bit          exp_err[int];

    bit          m_done, m_tout;
    logic [31:0] m_code, m_hb;
    int          m_R;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle=%0d got=0x%08x want=0x%08x",
                     n, tcyc, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) tcyc <= 0;
        else        tcyc <= tcyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_done = 0; m_tout = 0; m_code = 0; m_hb = 0; m_R = 0;
            chk("rst_done", done_o, 0);
            chk("rst_tout", tout_o, 0);
            chk("rst_code", code_o, 0);
            chk("rst_hb", hb_o, 0);
            chk("rst_rdata", d_o, 0);
            chk("rst_rvalid", dv_o, 0);
            chk("rst_rend", end_o, 0);
            chk("rst_err", err_o, 0);
        end else begin
            if (ev_hb.exists(tcyc)) begin
                m_hb = m_hb + 1;
                m_R  = tcyc;
            end
            if (ev_exit.exists(tcyc) && !m_done) begin
                m_done = 1;
                m_code = ev_exit[tcyc];
            end else if (!m_done && (tcyc - m_R == WD)) begin
                m_done = 1;
                m_tout = 1;
                m_code = TOC;
            end
            chk("done", done_o, m_done);
            chk("timeout", tout_o, m_tout);
            chk("exit_code", code_o, m_code);
            chk("hb_cnt", hb_o, m_hb);
            chk("rd_valid", dv_o, exp_rd.exists(tcyc));
            chk("rd_data", d_o, exp_rd.exists(tcyc) ? exp_rd[tcyc] : 32'd0);
            chk("rd_end", end_o, exp_end.exists(tcyc));
            chk("bus_error", err_o, exp_err.exists(tcyc));
            chk("busy", busy_o, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        a_i = 0; be_i = 0; bs_i = 0; rnw_i = 0;
        beg_i = 0; end_i = 0; dv_i = 0;
    endtask

    task automatic clear_model();
        ev_hb.delete(); ev_exit.delete(); exp_rd.delete();
        exp_end.delete(); exp_err.delete();
    endtask

    task automatic finish_reset();
        clear_model();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 0;
        idle_bus();
        finish_reset();
    endtask

    task automatic wr(input logic [31:0] a, input int nb,
                      input logic [31:0] d, output int t);
        int off;
        bit hit, ok;
        step();
        t = tcyc;
        beg_i = 1; a_i = a; rnw_i = 0; bs_i = nb[7:0]; be_i = 4'hF;
        hit = (a[31:4] == BASE[31:4]);
        off = int'(a[3:2]);
        ok  = hit && (off + nb <= 3);
        if (hit && !ok) exp_err[t + 1] = 1;
        for (int i = 0; i <= nb; i++) begin
            step();
            beg_i = 0; dv_i = 1; a_i = d + i; end_i = (i == nb);
            if (ok && off + i == 0) ev_exit[t + 2 + i] = d + i;
            if (ok && off + i == 1) ev_hb[t + 2 + i] = 1;
        end
        step();
        idle_bus();
    endtask

    task automatic rd(input logic [31:0] a, input int nb,
                      output int t, output logic [31:0] cap);
        int off;
        step();
        t = tcyc;
        beg_i = 1; a_i = a; rnw_i = 1; bs_i = nb[7:0]; be_i = 4'hF;
        off = int'(a[3:2]);
        if (a[31:4] == BASE[31:4]) begin
            if (off + nb > 3) begin
                exp_err[t + 1] = 1;
            end else begin
                for (int i = 0; i <= nb; i++)
                    exp_rd[t + 2 + i] = (off + i == 2) ? t + 2 + i : 0;
                exp_end[t + 3 + nb] = 1;
            end
        end
        step();
        idle_bus();
        step();
        cap = d_o;
        repeat (nb + 3) step();
    endtask

    int          t, t2;
    logic [31:0] cap;

    initial begin
        idle_bus();
        finish_reset();

        // Single EXIT write, then a later EXIT is ignored.
        do_reset();
        wr(BASE, 0, 32'h2A, t);
        @(negedge clk);
        chk("exit_done", done_o, 1);
        chk("exit_code_2A", code_o, 32'h2A);
        chk("exit_no_tout", tout_o, 0);

        do_reset();
        wr(BASE, 0, 32'h1, t);
        wr(BASE, 0, 32'h2, t);
        @(negedge clk);
        chk("first_exit_wins", code_o, 32'h1);

        // Burst EXIT+HEARTBEAT, boundary burst, non-hit, error write.
        do_reset();
        wr(BASE, 1, 32'h10, t);
        @(negedge clk);
        chk("burst_exit", code_o, 32'h10);
        chk("burst_hb", hb_o, 1);
        wr(BASE + 4, 2, 32'h5, t);
        wr(32'h7000_0014, 0, 32'h0, t);
        wr(BASE + 8, 3, 32'h0, t);
        wr(BASE + 4, 3, 32'h0, t);
        wr(BASE + 4, 0, 32'h0, t);
        @(negedge clk);
        chk("hb_after_err", hb_o, 3);

        // Reads: CYCLES burst, full window, 0xC, errors, non-hit.
        do_reset();
        rd(BASE + 8, 1, t, cap);
        chk("rd_first_beat", cap, t + 2);
        rd(BASE, 3, t, cap);
        rd(BASE + 12, 0, t, cap);
        rd(BASE + 4, 3, t, cap);
        rd(32'h6000_0008, 0, t, cap);
        rd(BASE + 8, 0, t, cap);

        // Reset in the middle of a read burst after done was set.
        do_reset();
        wr(BASE, 0, 32'h55, t);
        step();
        beg_i = 1; a_i = BASE + 8; rnw_i = 1; bs_i = 8'd1;
        step();
        idle_bus();
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("mid_rst_valid", dv_o, 0);
        chk("mid_rst_data", d_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_code", code_o, 0);
        finish_reset();
        rd(BASE + 8, 0, t, cap);
        chk("rst_cyc_restart", cap, 32'd3);

        // EXIT lands on the expiry cycle.
        do_reset();
        while (tcyc < 97) step();
        wr(BASE, 0, 32'h77, t);
        @(negedge clk);
        chk("exit_vs_wdog_t", t, 98);
        chk("exit_vs_wdog_code", code_o, 32'h77);
        chk("exit_vs_wdog_tout", tout_o, 0);

        // Heartbeat lands on the expiry cycle.
        do_reset();
        while (tcyc < 97) step();
        wr(BASE + 4, 0, 32'h0, t);
        while (tcyc < 199) step();
        @(negedge clk);
        chk("hb_vs_wdog_199", done_o, 0);
        step();
        @(negedge clk);
        chk("hb_vs_wdog_200", tout_o, 1);

        // Periodic heartbeats, then let the watchdog fire.
        do_reset();
        t2 = 0;
        for (int i = 0; i < 20; i++) begin
            while (tcyc < 10 + 50 * i) step();
            wr(BASE + 4, 0, i, t2);
        end
        @(negedge clk);
        chk("hb_twenty", hb_o, 20);
        chk("hb_alive", done_o, 0);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_o) break;
        end
        chk("wdog_cycle", tcyc, t2 + 102);
        chk("wdog_tout", tout_o, 1);
        chk("wdog_code", code_o, 32'hDEAD0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
